// File: rtl/uart_rx_fifo.sv
// UART receiver with optional parity check, feeding a show-ahead FIFO.
// Sticky error flags are raised by line events; the interrupt level is driven by FIFO occupancy.
module uart_rx_fifo #(
    parameter int WAIT      = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx,
    input  logic                       intr_en,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_BITS-1:0]       r_data,
    output logic                       r_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       irr,
    output logic                       overrun,
    output logic                       frame_err,
    output logic                       parity_err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(WAIT);
    localparam int BW   = $clog2(DATA_BITS);

    // state     | meaning
    // WAIT_IDLE | line must return high before a start bit is accepted
    // IDLE      | waiting for a falling edge
    // START     | mid-start-bit check; DATA / PAR / STOP sample one bit per WAIT
    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic                   irr_q, irr_d;
    logic                   overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];

    logic push, fe_ev, pe_ev, tick, exp_par;
    logic pop, full, push_ok, drop;

    assign tick    = (cyc_q == '0);
    assign exp_par = (PARITY == 2) ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = tick ? cyc_q : cyc_q - CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push      = 1'b0;
        fe_ev     = 1'b0;
        pe_ev     = 1'b0;
        case (state_q)
            S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
            S_IDLE: begin
                if (!rx_s_q) begin
                    cyc_d   = CW'(WAIT / 2 - 1);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cyc_d     = CW'(WAIT - 1);
                        bit_d     = BW'(DATA_BITS - 1);
                        par_bad_d = 1'b0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    cyc_d   = CW'(WAIT - 1);
                    if (bit_q == '0) state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    else             bit_d   = bit_q - BW'(1);
                end
            end
            S_PAR: begin
                if (tick) begin
                    par_bad_d = (rx_s_q != exp_par);
                    cyc_d     = CW'(WAIT - 1);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        pe_ev   = par_bad_q;
                        push    = ~par_bad_q;
                        state_d = S_IDLE;
                    end else begin
                        fe_ev   = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop     = rd_en & (count_q != '0);
    assign full    = (count_q == CNTW'(DEPTH));
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d     = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        irr_d        = intr_en & (count_q >= CNTW'(IRQ_LEVEL));
        overrun_d    = (overrun_q & ~err_clr) | drop;
        frame_err_d  = (frame_err_q & ~err_clr) | fe_ev;
        parity_err_d = (parity_err_q & ~err_clr) | pe_ev;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT_IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            irr_q        <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            irr_q        <= irr_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign r_valid    = (count_q != '0);
    assign r_data     = r_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign irr        = irr_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: unit A uses default parameters, unit B uses even parity and an interrupt level of 3.
module tb_uart_rx_fifo;
    localparam int W     = 16;
    localparam int BOUND = 3 + W / 2 + 9 * W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       rx_a, ie_a, rd_a, ec_a, rv_a, irr_a, ov_a, fe_a, pe_a;
    logic [7:0] rdata_a;
    logic [2:0] cnt_a;
    logic       rx_b, ie_b, rd_b, ec_b, rv_b, irr_b, ov_b, fe_b, pe_b;
    logic [7:0] rdata_b;
    logic [2:0] cnt_b;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.WAIT(W), .DATA_BITS(8), .PARITY(0), .DEPTH(4), .IRQ_LEVEL(1)) dut_a (
        .clk(clk), .reset(reset), .uart_rx(rx_a), .intr_en(ie_a), .rd_en(rd_a), .err_clr(ec_a),
        .r_data(rdata_a), .r_valid(rv_a), .count(cnt_a), .irr(irr_a),
        .overrun(ov_a), .frame_err(fe_a), .parity_err(pe_a));

    uart_rx_fifo #(.WAIT(W), .DATA_BITS(8), .PARITY(1), .DEPTH(4), .IRQ_LEVEL(3)) dut_b (
        .clk(clk), .reset(reset), .uart_rx(rx_b), .intr_en(ie_b), .rd_en(rd_b), .err_clr(ec_b),
        .r_data(rdata_b), .r_valid(rv_b), .count(cnt_b), .irr(irr_b),
        .overrun(ov_b), .frame_err(fe_b), .parity_err(pe_b));

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_cnt;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Called at posedge+1; returns at posedge+1 with the line idle high.
    task automatic send_frame(input int sel, input logic [8:0] bits, input int nb, input logic stop);
        set_rx(sel, 1'b0);
        tick(W);
        for (int i = 0; i < nb; i++) begin
            set_rx(sel, bits[i]);
            tick(W);
        end
        set_rx(sel, stop);
        tick(W);
        set_rx(sel, 1'b1);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) rd_a = 1'b1; else rd_b = 1'b1;
        tick(1);
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    task automatic clr(input int sel);
        if (sel == 0) ec_a = 1'b1; else ec_b = 1'b1;
        tick(1);
        ec_a = 1'b0;
        ec_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wb [5];
        logic       found;

        tbl[0] = '{8'h55, 1'b1, 1, 8'h55, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
        tbl[4] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
        tbl[5] = '{8'h96, 1'b0, 0, 8'h00, 1'b1};
        wb = '{8'h13, 8'h22, 8'h37, 8'h44, 8'h5B};

        reset = 1'b0;
        rx_a = 1'b1; ie_a = 1'b1; rd_a = 1'b0; ec_a = 1'b0;
        rx_b = 1'b1; ie_b = 1'b0; rd_b = 1'b0; ec_b = 1'b0;
        #2;
        chk("rst_count_a", cnt_a, 0);
        chk("rst_valid_a", rv_a, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_irr_a", irr_a, 0);
        chk("rst_flags_a", {ov_a, fe_a, pe_a}, 0);
        chk("rst_count_b", cnt_b, 0);
        tick(3);
        reset = 1'b1;
        tick(4);

        // Single word latency, interrupt and pop.
        found = 1'b0;
        fork
            send_frame(0, {1'b0, 8'h8F}, 8, 1'b1);
            begin
                for (int k = 1; k <= BOUND; k++) begin
                    tick(1);
                    if (rv_a) begin
                        found = 1'b1;
                        break;
                    end
                end
            end
        join
        chk("t1_latency", found, 1);
        chk("t1_rdata", rdata_a, 8'h8F);
        chk("t1_count", cnt_a, 1);
        chk("t1_irr", irr_a, 1);
        pop(0);
        chk("t1_count_after_pop", cnt_a, 0);
        chk("t1_valid_after_pop", rv_a, 0);
        chk("t1_irr_lags", irr_a, 1);
        tick(1);
        chk("t1_irr_cleared", irr_a, 0);
        tick(4);

        for (int i = 0; i < 6; i++) begin
            send_frame(0, {1'b0, tbl[i].data}, 8, tbl[i].stop);
            tick(4);
            chk($sformatf("vec%0d_count", i), cnt_a, tbl[i].exp_cnt);
            chk($sformatf("vec%0d_rdata", i), rdata_a, tbl[i].exp_data);
            chk($sformatf("vec%0d_frame_err", i), fe_a, tbl[i].exp_fe);
            if (tbl[i].exp_cnt != 0) pop(0);
            clr(0);
            chk($sformatf("vec%0d_fe_clr", i), fe_a, 0);
            tick(4);
        end

        // Framing error, then line held low: no frames until the line returns high.
        send_frame(0, {1'b0, 8'h3C}, 8, 1'b0);
        rx_a = 1'b0;
        tick(3 * W);
        rx_a = 1'b1;
        tick(2 * W);
        chk("t4_frame_err", fe_a, 1);
        chk("t4_no_spurious", cnt_a, 0);
        send_frame(0, {1'b0, 8'h55}, 8, 1'b1);
        tick(3);
        chk("t4_rdata", rdata_a, 8'h55);
        chk("t4_count", cnt_a, 1);
        pop(0);
        clr(0);
        tick(4);

        // Overrun: five words into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(0, {1'b0, 8'(i)}, 8, 1'b1);
        tick(3);
        chk("t2_count_full", cnt_a, 4);
        chk("t2_overrun", ov_a, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t2_pop%0d", i), rdata_a, i);
            pop(0);
        end
        chk("t2_empty", rv_a, 0);
        chk("t2_rdata_empty", rdata_a, 0);
        clr(0);
        chk("t2_overrun_clr", ov_a, 0);
        tick(4);

        // Glitch shorter than half a bit.
        rx_a = 1'b0;
        tick(W / 4);
        rx_a = 1'b1;
        tick(3 * W);
        chk("t5_glitch_count", cnt_a, 0);
        chk("t5_glitch_flags", {ov_a, fe_a, pe_a}, 0);

        // Reset in the middle of a frame with a word already buffered.
        send_frame(0, {1'b0, 8'h5A}, 8, 1'b1);
        tick(3);
        chk("t5_pre_reset_count", cnt_a, 1);
        rx_a = 1'b0;
        tick(W);
        for (int i = 0; i < 4; i++) begin
            rx_a = (8'hC3 >> i) & 1'b1;
            tick(W);
        end
        reset = 1'b0;
        #1;
        chk("t5_rst_count", cnt_a, 0);
        chk("t5_rst_valid", rv_a, 0);
        chk("t5_rst_rdata", rdata_a, 0);
        chk("t5_rst_irr", irr_a, 0);
        rx_a = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(4);
        send_frame(0, {1'b0, 8'hC3}, 8, 1'b1);
        tick(3);
        chk("t5_after_rst_rdata", rdata_a, 8'hC3);
        chk("t5_after_rst_count", cnt_a, 1);
        pop(0);

        // Even parity: A5 has four ones, so the correct parity bit is 0.
        send_frame(1, {1'b0, 8'hA5}, 9, 1'b1);
        tick(3);
        chk("t3_count", cnt_b, 1);
        chk("t3_rdata", rdata_b, 8'hA5);
        chk("t3_parity_ok", pe_b, 0);
        send_frame(1, {1'b1, 8'hA5}, 9, 1'b1);
        tick(3);
        chk("t3_count_unchanged", cnt_b, 1);
        chk("t3_parity_err", pe_b, 1);
        chk("t3_no_frame_err", fe_b, 0);
        pop(1);
        clr(1);
        chk("t3_parity_clr", pe_b, 0);
        tick(4);

        // Interrupt level 3, then push and pop together on a full FIFO.
        ie_b = 1'b1;
        send_frame(1, {^wb[0], wb[0]}, 9, 1'b1);
        send_frame(1, {^wb[1], wb[1]}, 9, 1'b1);
        tick(3);
        chk("t6_count2", cnt_b, 2);
        chk("t6_irr_below_level", irr_b, 0);
        send_frame(1, {^wb[2], wb[2]}, 9, 1'b1);
        tick(3);
        chk("t6_irr_at_level", irr_b, 1);
        send_frame(1, {^wb[3], wb[3]}, 9, 1'b1);
        tick(3);
        chk("t6_count_full", cnt_b, 4);
        fork
            send_frame(1, {^wb[4], wb[4]}, 9, 1'b1);
            begin
                tick(3 + W / 2 + 10 * W - 1);
                rd_b = 1'b1;
                tick(1);
                rd_b = 1'b0;
            end
        join
        tick(2);
        chk("t6_count_stays_full", cnt_b, 4);
        chk("t6_no_overrun", ov_b, 0);
        chk("t6_head", rdata_b, wb[1]);
        ie_b = 1'b0;
        tick(1);
        chk("t6_irr_disabled", irr_b, 0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t6_pop%0d", i), rdata_b, wb[i]);
            pop(1);
        end
        chk("t6_empty", rv_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the mother_board UART receive path.
- Receives asynchronous serial frames on uart_rx with configurable data width and parity, and buffers the received words in a show-ahead FIFO.
- Raises a level-sensitive interrupt request toward the cpu interrupt logic (irr).
- Replaces the single-byte r_data/irr holding register, which has no buffering, no error detection and acknowledge-by-software only.

Parameters:
- WAIT, 16: clock cycles per bit; must be >= 4.
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- IRQ_LEVEL, 1: irr asserts when count >= IRQ_LEVEL; legal range 1..DEPTH.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- uart_rx, in, 1: serial line, idle high.
- intr_en, in, 1: interrupt enable.
- rd_en, in, 1: pop FIFO head on this clock edge.
- err_clr, in, 1: clear all sticky error flags.
- r_data, out, DATA_BITS: FIFO head (show-ahead); 0 when empty.
- r_valid, out, 1: FIFO not empty.
- count, out, $clog2(DEPTH)+1: FIFO occupancy.
- irr, out, 1: interrupt request.
- overrun, out, 1: sticky; a word was dropped because the FIFO was full.
- frame_err, out, 1: sticky; stop bit sampled low.
- parity_err, out, 1: sticky; parity mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; count=0, r_valid=0, r_data=0, irr=0, all error flags 0.
  - Both synchroniser flops set to 1.
  - FSM enters WAIT_IDLE.
- uart_rx passes through a 2-flop synchroniser; rx_s below is the synchronised value. Bit counter and cycle counter are internal.
- FSM states and transitions:
  - WAIT_IDLE: go to IDLE when rx_s=1. Guards against reset release or a framing error while the line is low or in break.
  - IDLE: when rx_s=0, clear the cycle counter and go to START.
  - START: at cycle WAIT/2, sample rx_s.
    - 1: glitch; go to IDLE, no flags.
    - 0: restart the counter and go to DATA.
  - DATA: sample rx_s every WAIT cycles into shift register bit i, LSB first. After DATA_BITS samples go to PAR if PARITY!=0, else STOP.
  - PAR: sample after WAIT cycles and compare against computed parity. Mismatch is held pending until STOP.
  - STOP: sample after WAIT cycles.
    - rx_s=1 and no parity mismatch: push word, go to IDLE.
    - rx_s=1 with parity mismatch: word discarded, parity_err<=1, go to IDLE.
    - rx_s=0: word discarded, frame_err<=1 (parity_err is not also set), go to WAIT_IDLE.
- Push timing:
  - The word is written on the stop-sample edge.
  - r_valid/count/r_data reflect it on the following cycle.
  - Bound: r_valid rises no later than 3 + WAIT/2 + (DATA_BITS + (PARITY!=0) + 1)*WAIT cycles after the uart_rx falling edge.
- FIFO:
  - Circular buffer with read/write pointers, wrap modulo DEPTH.
  - rd_en with count=0: ignored, no state change.
  - Push with count=DEPTH and no pop the same edge: word dropped, overrun<=1, FIFO contents unchanged.
  - Push and pop on the same edge:
    - When full: both take effect, count stays DEPTH, no overrun.
    - When empty: pop ignored, push lands, count=1.
- Interrupt: irr = intr_en & (count >= IRQ_LEVEL), registered, so it updates one cycle after count. Acknowledge is by popping below IRQ_LEVEL; there is no separate ack bit.
- Error flags:
  - err_clr clears all three flags on the next edge.
  - If err_clr coincides with a new error event on the same edge, the flag ends set.
  - Error flags do not affect irr.

Test Plan:
1. Default params; send 8'h8F at WAIT cycles/bit -> within the latency bound r_valid=1, r_data=8'h8F, count=1. With intr_en=1, irr=1. One-cycle rd_en -> count=0, r_valid=0, irr=0 one cycle later.
2. DEPTH=4; send 8'h01..8'h05 back to back with no reads -> count=4, overrun=1. Pops return 01,02,03,04 in order, then r_valid=0. err_clr -> overrun=0.
3. PARITY=1; send 8'hA5 with correct parity bit 0 -> word stored. Resend with parity bit 1 -> no push, parity_err=1, count unchanged.
4. Stop bit forced 0 for 8'h3C -> frame_err=1, no push. Hold line low 3*WAIT cycles -> no spurious frames. Line high, then 8'h55 -> received correctly.
5. Line low pulse of WAIT/4 cycles -> no push, no flags. Reset asserted mid-frame after 4 data bits -> all outputs 0 immediately; next full 8'hC3 after release received intact.
6. IRQ_LEVEL=3, intr_en=1: irr stays 0 after 2 words and rises after the 3rd. With a full FIFO, rd_en coinciding with the stop sample -> count stays 4, overrun stays 0. intr_en=0 -> irr=0 next cycle.
